// File: rtl/multicycle_controller.sv
// Control FSM for the shared-ALU, shared-memory multicycle RISC-V datapath.
// Sequences fetch/decode/execute/memory/writeback with a memory wait timeout.
module multicycle_controller #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       SignFlag,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] state,
  output logic       illegal_instr,
  output logic       mem_timeout
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECUTER = 4'd6;
  localparam logic [3:0] EXECUTEI = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BRANCH   = 4'd9;

  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_B  = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b010;

  logic [3:0]       st, st_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             wait_st, tmo, taken;
  logic [2:0]       ex_alu;

  assign state   = st;
  assign wait_st = (st == FETCH) | (st == MEMREAD) | (st == MEMWRITE);
  assign tmo     = wait_st & ~mem_ready & (cnt == CNT_W'(TIMEOUT - 1));
  assign cnt_n   = (wait_st & ~mem_ready & ~tmo) ? cnt + 1'b1 : '0;

  always_comb begin
    ex_alu = ALU_ADD;
    unique case (funct3)
      3'b000:  ex_alu = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001,
      3'b100,
      3'b101,
      3'b110,
      3'b111:  ex_alu = funct3;
      default: ex_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    unique case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = ~Zero;
      3'b100:  taken = SignFlag;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    st_n          = st;
    PCWrite       = 1'b0;
    AdrSrc        = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ImmSrc        = 2'b00;
    ALUControl    = ALU_ADD;
    illegal_instr = 1'b0;
    mem_timeout   = 1'b0;
    unique case (1'b1)
      op == OP_SW: ImmSrc = 2'b01;
      op == OP_B:  ImmSrc = 2'b10;
      default:     ImmSrc = 2'b00;
    endcase
    case (st)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) st_n = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        unique case (1'b1)
          op == OP_LW,
          op == OP_SW: st_n = MEMADR;
          op == OP_R:  st_n = EXECUTER;
          op == OP_I:  st_n = EXECUTEI;
          op == OP_B:  st_n = BRANCH;
          default: begin
            st_n          = FETCH;
            illegal_instr = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        st_n    = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) st_n = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        st_n      = FETCH;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) st_n = FETCH;
      end
      EXECUTER, EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = (st == EXECUTEI) ? 2'b01 : 2'b00;
        ALUControl = ex_alu;
        st_n       = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        st_n     = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        PCWrite    = taken;
        st_n       = FETCH;
      end
      default: st_n = FETCH;
    endcase
    // an aborted wait must not commit anything
    if (tmo) begin
      PCWrite     = 1'b0;
      IRWrite     = 1'b0;
      MemWrite    = 1'b0;
      RegWrite    = 1'b0;
      mem_timeout = 1'b1;
      st_n        = FETCH;
    end
    if (reset) begin
      PCWrite       = 1'b0;
      AdrSrc        = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      RegWrite      = 1'b0;
      ResultSrc     = 2'b00;
      ALUSrcA       = 2'b00;
      ALUSrcB       = 2'b00;
      ImmSrc        = 2'b00;
      ALUControl    = ALU_ADD;
      illegal_instr = 1'b0;
      mem_timeout   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st  <= FETCH;
      cnt <= '0;
    end else begin
      st  <= st_n;
      cnt <= cnt_n;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed and random instructions
// compared cycle by cycle against a per-instruction expected schedule.
module tb_multicycle_controller;

  localparam int TO = 16;

  localparam logic [6:0] LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011;
  localparam logic [6:0] RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, SignFlag, mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;
  logic       illegal_instr, mem_timeout;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] res, a, b, imm;
    logic [2:0] alu;
    logic       ill, tmo;
  } rec_t;

  rec_t got;
  rec_t q[$];
  bit   mrq[$];
  int   checks = 0;
  int   failures = 0;

  assign got = {state, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
                illegal_instr, mem_timeout};

  multicycle_controller #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .Zero(Zero), .SignFlag(SignFlag),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .state(state),
    .illegal_instr(illegal_instr), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, rec_t e);
    checks++;
    assert (got === e) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, e);
    end
  endtask

  function automatic rec_t base(logic [3:0] s, logic [6:0] o);
    rec_t r = '0;
    r.st  = s;
    r.imm = (o == SW) ? 2'b01 : (o == BR) ? 2'b10 : 2'b00;
    return r;
  endfunction

  task automatic push(rec_t r, bit mr);
    q.push_back(r);
    mrq.push_back(mr);
  endtask

  // n idle cycles, then completion unless n reaches the timeout limit
  task automatic wait_phase(rec_t r, rec_t fin, int n, output bit ab);
    for (int i = 0; i < n && i < TO; i++) begin
      rec_t w = r;
      if (i == TO - 1) begin
        w.tmo = 1'b1;
        w.mw  = 1'b0;
      end
      push(w, 1'b0);
    end
    ab = (n >= TO);
    if (!ab) push(fin, 1'b1);
  endtask

  task automatic plan(logic [6:0] o, logic [2:0] f3, logic f7,
                      logic z, logic s, int fw, int mw);
    rec_t r, fin;
    bit   ab;
    r = base(4'd0, o);
    r.b = 2'b10;
    r.res = 2'b10;
    fin = r;
    fin.irw = 1'b1;
    fin.pcw = 1'b1;
    wait_phase(r, fin, fw, ab);
    if (ab) return;
    r = base(4'd1, o);
    r.a = 2'b01;
    r.b = 2'b01;
    if (!(o inside {LW, SW, RT, IT, BR})) begin
      r.ill = 1'b1;
      push(r, 1'($urandom));
      return;
    end
    push(r, 1'($urandom));
    if (o == LW || o == SW) begin
      r = base(4'd2, o);
      r.a = 2'b10;
      r.b = 2'b01;
      push(r, 1'($urandom));
      r = base((o == LW) ? 4'd3 : 4'd5, o);
      r.adr = 1'b1;
      r.mw = (o == SW);
      wait_phase(r, r, mw, ab);
      if (ab || o == SW) return;
      r = base(4'd4, o);
      r.res = 2'b01;
      r.rw = 1'b1;
      push(r, 1'($urandom));
    end else if (o == BR) begin
      r = base(4'd9, o);
      r.a = 2'b10;
      r.alu = 3'b010;
      r.pcw = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z) || (f3 == 3'd4 && s);
      push(r, 1'($urandom));
    end else begin
      r = base((o == RT) ? 4'd6 : 4'd7, o);
      r.a = 2'b10;
      r.b = (o == RT) ? 2'b00 : 2'b01;
      if (f3 == 3'b010 || f3 == 3'b011) r.alu = 3'b000;
      else if (f3 == 3'b000 && o[5] && f7) r.alu = 3'b010;
      else r.alu = f3;
      push(r, 1'($urandom));
      r = base(4'd8, o);
      r.rw = 1'b1;
      push(r, 1'($urandom));
    end
  endtask

  // entered and left at posedge+1 of an instruction's first cycle
  task automatic do_instr(string tag, logic [6:0] o, logic [2:0] f3,
                          logic f7, logic z, logic s, int fw, int mw);
    op = o;
    funct3 = f3;
    funct7b5 = f7;
    Zero = z;
    SignFlag = s;
    q.delete();
    mrq.delete();
    plan(o, f3, f7, z, s, fw, mw);
    while (q.size() > 0) begin
      rec_t e = q.pop_front();
      mem_ready = mrq.pop_front();
      @(negedge clk);
      chk(tag, e);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rec_t e;
    logic [6:0] o;
    int k, fw, mw;
    reset = 1'b1;
    op = 7'd0;
    funct3 = 3'd0;
    funct7b5 = 1'b0;
    Zero = 1'b0;
    SignFlag = 1'b0;
    mem_ready = 1'b1;
    #12;
    op = SW;
    #1;
    chk("reset_zero", '0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    do_instr("add", RT, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
    do_instr("sub", RT, 3'b000, 1'b1, 1'b0, 1'b0, 0, 0);
    do_instr("addi", IT, 3'b000, 1'b1, 1'b0, 1'b0, 0, 0);
    do_instr("lw_wait3", LW, 3'b010, 1'b0, 1'b0, 1'b0, 0, 3);
    do_instr("beq_t", BR, 3'b000, 1'b0, 1'b1, 1'b0, 0, 0);
    do_instr("bne_nt", BR, 3'b001, 1'b0, 1'b1, 1'b0, 0, 0);
    do_instr("blt_t", BR, 3'b100, 1'b0, 1'b0, 1'b1, 0, 0);
    do_instr("br_f3_010", BR, 3'b010, 1'b0, 1'b1, 1'b1, 0, 0);
    do_instr("illegal", 7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
    do_instr("sw_timeout", SW, 3'b010, 1'b0, 1'b0, 1'b0, 0, TO);
    do_instr("sw_edge", SW, 3'b010, 1'b0, 1'b0, 1'b0, 1, TO - 1);
    do_instr("fetch_timeout", LW, 3'b010, 1'b0, 1'b0, 1'b0, TO, 0);
    do_instr("sll", RT, 3'b001, 1'b1, 1'b0, 1'b0, 2, 0);

    // async reset while a store is waiting on memory
    op = SW;
    funct3 = 3'b010;
    mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    @(negedge clk);
    e = base(4'd5, SW);
    e.adr = 1'b1;
    e.mw = 1'b1;
    chk("sw_before_rst", e);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async", '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    do_instr("after_rst", RT, 3'b110, 1'b0, 1'b0, 1'b0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 5);
      case (k)
        0: o = LW;
        1: o = SW;
        2: o = RT;
        3: o = IT;
        4: o = BR;
        default: begin
          o = 7'($urandom);
          if (o inside {LW, SW, RT, IT, BR}) o = 7'b1101111;
        end
      endcase
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) fw = ($urandom % 2) ? TO : TO - 1;
      if ($urandom_range(0, 5) == 0) mw = ($urandom % 2) ? TO : TO - 1;
      do_instr("rand", o, 3'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), fw, mw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
